// File: rtl/frame_sink_writer.sv
// Drains a FWFT pixel FIFO into a linear frame buffer in raster order and pulses frame_done.
// Optional FRAME_CHECKSUM_EN adds a 32-bit running sum of the popped pixels.
module frame_sink_writer #(
  parameter int                DWIDTH     = 8,
  parameter int                IMG_WIDTH  = 720,
  parameter int                IMG_HEIGHT = 540,
  parameter int                AWIDTH     = 20,
  parameter logic [AWIDTH-1:0] BASE_ADDR  = '0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  output logic              fifo_rd_en,
  input  logic [DWIDTH-1:0] fifo_dout,
  input  logic              fifo_empty,
  output logic              mem_wr_en,
  output logic [AWIDTH-1:0] mem_addr,
  output logic [DWIDTH-1:0] mem_din,
  input  logic              mem_ready,
  output logic              busy,
  output logic              frame_done
`ifdef FRAME_CHECKSUM_EN
  ,
  output logic [31:0]       checksum
`endif
);

  localparam int NPIX = IMG_WIDTH * IMG_HEIGHT;
  localparam int PW   = (NPIX > 1) ? $clog2(NPIX) : 1;
  localparam logic [PW-1:0] LAST_PIX = PW'(NPIX - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    DRAIN = 2'b10,
    DONE  = 2'b11
  } state_t;

  state_t            state_q;
  logic [PW-1:0]     pix_q;
  logic [PW-1:0]     pix_d;
  logic              wrEn_q;
  logic [AWIDTH-1:0] addr_q;
  logic [DWIDTH-1:0] din_q;
  logic              busy_q;
  logic              done_q;
  logic              pop;

  // The output register is a one-deep buffer: refill it when empty or when it drains this edge.
  assign pop   = !reset && (state_q == RUN) && !fifo_empty && (!wrEn_q || mem_ready);
  assign pix_d = pix_q + PW'(1);

  assign fifo_rd_en = pop;
  assign mem_wr_en  = wrEn_q;
  assign mem_addr   = addr_q;
  assign mem_din    = din_q;
  assign busy       = busy_q;
  assign frame_done = done_q;

`ifdef FRAME_CHECKSUM_EN
  logic [31:0] csum_q;
  logic [31:0] csum_d;

  assign csum_d   = csum_q + 32'(fifo_dout);
  assign checksum = csum_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      csum_q <= '0;
    end else if (state_q == IDLE && start) begin
      csum_q <= '0;
    end else if (pop) begin
      csum_q <= csum_d;
    end
  end
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      pix_q   <= '0;
      wrEn_q  <= 1'b0;
      addr_q  <= '0;
      din_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            state_q <= RUN;
            pix_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        RUN: begin
          if (pop) begin
            wrEn_q <= 1'b1;
            din_q  <= fifo_dout;
            addr_q <= BASE_ADDR + AWIDTH'(pix_q);
            pix_q  <= pix_d;
            if (pix_q == LAST_PIX) begin
              state_q <= DRAIN;
            end
          end else if (wrEn_q && mem_ready) begin
            wrEn_q <= 1'b0;
          end
        end
        // The last pixel sits in the output register until memory takes it.
        DRAIN: begin
          if (mem_ready) begin
            wrEn_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_frame_sink_writer.sv
// Directed testbench for frame_sink_writer on a 4x3 frame at base address 0x100.
// Models the FWFT FIFO and the memory port; define FRAME_CHECKSUM_EN to also check the checksum.
module tb_frame_sink_writer;

  localparam int                DW   = 8;
  localparam int                AW   = 20;
  localparam int                NPIX = 12;
  localparam logic [AW-1:0]     BASE = 20'h100;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          fifo_rd_en;
  logic [DW-1:0] fifo_dout;
  logic          fifo_empty;
  logic          mem_wr_en;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_din;
  logic          mem_ready = 1'b1;
  logic          busy;
  logic          frame_done;
`ifdef FRAME_CHECKSUM_EN
  logic [31:0]   checksum;
`endif

  int checks = 0;
  int errors = 0;

  // FIFO model: circular store with free-running pointers plus a gate that fakes emptiness.
  logic [7:0] fifoMem [64];
  int         fifoRd = 0;
  int         fifoWr = 0;
  logic       starveGate = 1'b0;
  logic       popPending = 1'b0;

  assign fifo_empty = (fifoRd == fifoWr) || starveGate;
  assign fifo_dout  = fifoMem[fifoRd % 64];

  // Monitor log of accepted writes and protocol counters, all append-only.
  logic [AW-1:0] wrAddr [128];
  logic [DW-1:0] wrData [128];
  int            wrCyc  [128];
  int wrCount = 0, popCount = 0, doneCount = 0, doneCyc = 0, cyc = 0;
  int rdWhileEmpty = 0, stallPops = 0, holdViol = 0, stallCycles = 0;
  logic          prevStall = 1'b0;
  logic [AW-1:0] prevAddr = '0;
  logic [DW-1:0] prevDin = '0;

  frame_sink_writer #(
    .DWIDTH    (DW),
    .IMG_WIDTH (4),
    .IMG_HEIGHT(3),
    .AWIDTH    (AW),
    .BASE_ADDR (BASE)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .fifo_rd_en(fifo_rd_en),
    .fifo_dout (fifo_dout),
    .fifo_empty(fifo_empty),
    .mem_wr_en (mem_wr_en),
    .mem_addr  (mem_addr),
    .mem_din   (mem_din),
    .mem_ready (mem_ready),
    .busy      (busy),
    .frame_done(frame_done)
`ifdef FRAME_CHECKSUM_EN
    ,
    .checksum  (checksum)
`endif
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc++;

  // The pop the DUT signalled takes effect just after the edge that consumed fifo_dout.
  always @(posedge clock) begin
    #1;
    if (popPending && fifoRd != fifoWr) fifoRd++;
  end

  // Inputs change only just after posedge, so the negedge view matches what the next edge sees.
  always @(negedge clock) begin
    popPending = (fifo_rd_en === 1'b1);
    if (fifo_rd_en === 1'b1) begin
      popCount++;
      if (fifo_empty) rdWhileEmpty++;
      if (mem_wr_en === 1'b1 && !mem_ready) stallPops++;
    end
    if (!reset) begin
      if (prevStall && (mem_wr_en !== 1'b1 || mem_addr !== prevAddr || mem_din !== prevDin))
        holdViol++;
      if (mem_wr_en === 1'b1 && mem_ready) begin
        if (wrCount < 128) begin
          wrAddr[wrCount] = mem_addr;
          wrData[wrCount] = mem_din;
          wrCyc[wrCount]  = cyc;
        end
        wrCount++;
      end
      if (mem_wr_en === 1'b1 && !mem_ready) stallCycles++;
      if (frame_done === 1'b1) begin
        doneCount++;
        doneCyc = cyc;
      end
    end
    prevStall = !reset && (mem_wr_en === 1'b1) && !mem_ready;
    prevAddr  = mem_addr;
    prevDin   = mem_din;
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic pushPixel(input logic [7:0] v);
    fifoMem[fifoWr % 64] = v;
    fifoWr++;
  endtask

  task automatic pulseStart();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic waitDone(input int doneBase, input int budget);
    int n = 0;
    while (doneCount == doneBase && n < budget) begin
      tick();
      n++;
    end
    tick();
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b0;
    mem_ready = 1'b1;
    starveGate = 1'b0;
    tick();
    tick();
    checks++; if (mem_wr_en !== 1'b0) begin errors++; $display("[TB] FAIL reset_wr_en: got %b expected 0", mem_wr_en); end
    checks++; if (mem_addr !== '0) begin errors++; $display("[TB] FAIL reset_addr: got %h expected 0", mem_addr); end
    checks++; if (mem_din !== '0) begin errors++; $display("[TB] FAIL reset_din: got %h expected 0", mem_din); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (frame_done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done: got %b expected 0", frame_done); end
    reset = 1'b0;
    tick();
    checks++; if (fifo_rd_en !== 1'b0) begin errors++; $display("[TB] FAIL idle_rd_en: got %b expected 0", fifo_rd_en); end
`ifdef FRAME_CHECKSUM_EN
    checks++; if (checksum !== 32'h0) begin errors++; $display("[TB] FAIL reset_checksum: got %h expected 0", checksum); end
`endif
  endtask

  task automatic test_continuous();
    int wb = wrCount;
    int db = doneCount;
    for (int i = 0; i < NPIX; i++) pushPixel(8'(i));
    mem_ready = 1'b1;
    pulseStart();
    waitDone(db, 100);
    checks++; if (doneCount - db !== 1) begin errors++; $display("[TB] FAIL cont_done_count: got %0d expected 1", doneCount - db); end
    checks++; if (wrCount - wb !== NPIX) begin errors++; $display("[TB] FAIL cont_write_count: got %0d expected %0d", wrCount - wb, NPIX); end
    for (int i = 0; i < NPIX; i++) begin
      checks++;
      if (wrAddr[wb+i] !== BASE + AW'(i) || wrData[wb+i] !== 8'(i)) begin
        errors++;
        $display("[TB] FAIL cont_write[%0d]: got %h/%h expected %h/%h", i, wrAddr[wb+i], wrData[wb+i], BASE + AW'(i), 8'(i));
      end
    end
    checks++; if (wrCyc[wb+NPIX-1] - wrCyc[wb] !== NPIX - 1) begin errors++; $display("[TB] FAIL cont_span: got %0d expected %0d", wrCyc[wb+NPIX-1] - wrCyc[wb], NPIX - 1); end
    checks++; if (doneCyc - wrCyc[wb+NPIX-1] !== 1) begin errors++; $display("[TB] FAIL cont_done_latency: got %0d expected 1", doneCyc - wrCyc[wb+NPIX-1]); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL cont_busy_after: got %b expected 0", busy); end
`ifdef FRAME_CHECKSUM_EN
    checks++; if (checksum !== 32'h42) begin errors++; $display("[TB] FAIL cont_checksum: got %h expected 42", checksum); end
`endif
  endtask

  task automatic test_back_to_back();
    int wb = wrCount;
    int db = doneCount;
    for (int i = 0; i < NPIX; i++) pushPixel(8'hFF);
    pulseStart();
    waitDone(db, 100);
    checks++; if (doneCount - db !== 1) begin errors++; $display("[TB] FAIL b2b_done_count: got %0d expected 1", doneCount - db); end
    checks++; if (wrCount - wb !== NPIX) begin errors++; $display("[TB] FAIL b2b_write_count: got %0d expected %0d", wrCount - wb, NPIX); end
    for (int i = 0; i < NPIX; i++) begin
      checks++;
      if (wrAddr[wb+i] !== BASE + AW'(i) || wrData[wb+i] !== 8'hFF) begin
        errors++;
        $display("[TB] FAIL b2b_write[%0d]: got %h/%h expected %h/ff", i, wrAddr[wb+i], wrData[wb+i], BASE + AW'(i));
      end
    end
`ifdef FRAME_CHECKSUM_EN
    checks++; if (checksum !== 32'hBF4) begin errors++; $display("[TB] FAIL b2b_checksum: got %h expected bf4", checksum); end
`endif
  endtask

  task automatic test_backpressure();
    int wb = wrCount;
    int db = doneCount;
    int hb = holdViol;
    int sb = stallPops;
    int cb = stallCycles;
    for (int i = 0; i < NPIX; i++) pushPixel(8'h20 + 8'(i));
    pulseStart();
    repeat (4) tick();
    mem_ready = 1'b0;
    repeat (3) tick();
    mem_ready = 1'b1;
    waitDone(db, 100);
    checks++; if (doneCount - db !== 1) begin errors++; $display("[TB] FAIL bp_done_count: got %0d expected 1", doneCount - db); end
    checks++; if (wrCount - wb !== NPIX) begin errors++; $display("[TB] FAIL bp_write_count: got %0d expected %0d", wrCount - wb, NPIX); end
    for (int i = 0; i < NPIX; i++) begin
      checks++;
      if (wrAddr[wb+i] !== BASE + AW'(i) || wrData[wb+i] !== 8'h20 + 8'(i)) begin
        errors++;
        $display("[TB] FAIL bp_write[%0d]: got %h/%h expected %h/%h", i, wrAddr[wb+i], wrData[wb+i], BASE + AW'(i), 8'h20 + 8'(i));
      end
    end
    checks++; if (stallCycles - cb !== 3) begin errors++; $display("[TB] FAIL bp_stall_cycles: got %0d expected 3", stallCycles - cb); end
    checks++; if (holdViol - hb !== 0) begin errors++; $display("[TB] FAIL bp_hold: got %0d changes expected 0", holdViol - hb); end
    checks++; if (stallPops - sb !== 0) begin errors++; $display("[TB] FAIL bp_pop_in_stall: got %0d expected 0", stallPops - sb); end
  endtask

  task automatic test_starved();
    int wb = wrCount;
    int db = doneCount;
    int eb = rdWhileEmpty;
    int pb = popCount;
    int busyDrops = 0;
    int n = 0;
    for (int i = 0; i < NPIX; i++) pushPixel(8'h50 + 8'(i));
    starveGate = 1'b1;
    pulseStart();
    while (doneCount == db && n < 200) begin
      tick();
      starveGate = ~starveGate;
      if (frame_done !== 1'b1 && doneCount == db && busy !== 1'b1) busyDrops++;
      n++;
    end
    starveGate = 1'b0;
    tick();
    tick();
    checks++; if (doneCount - db !== 1) begin errors++; $display("[TB] FAIL starve_done_count: got %0d expected 1", doneCount - db); end
    checks++; if (wrCount - wb !== NPIX) begin errors++; $display("[TB] FAIL starve_write_count: got %0d expected %0d", wrCount - wb, NPIX); end
    for (int i = 0; i < NPIX; i++) begin
      checks++;
      if (wrAddr[wb+i] !== BASE + AW'(i) || wrData[wb+i] !== 8'h50 + 8'(i)) begin
        errors++;
        $display("[TB] FAIL starve_write[%0d]: got %h/%h expected %h/%h", i, wrAddr[wb+i], wrData[wb+i], BASE + AW'(i), 8'h50 + 8'(i));
      end
    end
    checks++; if (wrCyc[wb+NPIX-1] - wrCyc[wb] !== 2 * (NPIX - 1)) begin errors++; $display("[TB] FAIL starve_span: got %0d expected %0d", wrCyc[wb+NPIX-1] - wrCyc[wb], 2 * (NPIX - 1)); end
    checks++; if (rdWhileEmpty - eb !== 0) begin errors++; $display("[TB] FAIL starve_rd_when_empty: got %0d expected 0", rdWhileEmpty - eb); end
    checks++; if (popCount - pb !== NPIX) begin errors++; $display("[TB] FAIL starve_pops: got %0d expected %0d", popCount - pb, NPIX); end
    checks++; if (busyDrops !== 0) begin errors++; $display("[TB] FAIL starve_busy: got %0d low cycles expected 0", busyDrops); end
  endtask

  task automatic test_reset_midframe();
    int wb = wrCount;
    int db = doneCount;
    int wb2;
    int n = 0;
    for (int i = 0; i < 6; i++) pushPixel(8'h60 + 8'(i));
    pulseStart();
    while (wrCount - wb < 5 && n < 50) begin
      tick();
      n++;
    end
    mem_ready = 1'b0;
    reset = 1'b1;
    tick();
    checks++; if (mem_wr_en !== 1'b0) begin errors++; $display("[TB] FAIL mid_wr_en: got %b expected 0", mem_wr_en); end
    checks++; if (mem_addr !== '0 || mem_din !== '0) begin errors++; $display("[TB] FAIL mid_addr_din: got %h/%h expected 0/0", mem_addr, mem_din); end
    checks++; if (busy !== 1'b0 || frame_done !== 1'b0) begin errors++; $display("[TB] FAIL mid_busy_done: got %b/%b expected 0/0", busy, frame_done); end
    checks++; if (fifo_rd_en !== 1'b0) begin errors++; $display("[TB] FAIL mid_rd_en: got %b expected 0", fifo_rd_en); end
`ifdef FRAME_CHECKSUM_EN
    checks++; if (checksum !== 32'h0) begin errors++; $display("[TB] FAIL mid_checksum: got %h expected 0", checksum); end
`endif
    reset = 1'b0;
    mem_ready = 1'b1;
    repeat (5) tick();
    checks++; if (doneCount - db !== 0) begin errors++; $display("[TB] FAIL mid_no_done: got %0d expected 0", doneCount - db); end
    checks++; if (wrCount - wb !== 5) begin errors++; $display("[TB] FAIL mid_writes: got %0d expected 5", wrCount - wb); end
    wb2 = wrCount;
    for (int i = 0; i < NPIX; i++) pushPixel(8'h70 + 8'(i));
    pulseStart();
    waitDone(db, 100);
    checks++; if (doneCount - db !== 1) begin errors++; $display("[TB] FAIL mid_restart_done: got %0d expected 1", doneCount - db); end
    checks++; if (wrCount - wb2 !== NPIX) begin errors++; $display("[TB] FAIL mid_restart_count: got %0d expected %0d", wrCount - wb2, NPIX); end
    for (int i = 0; i < NPIX; i++) begin
      checks++;
      if (wrAddr[wb2+i] !== BASE + AW'(i) || wrData[wb2+i] !== 8'h70 + 8'(i)) begin
        errors++;
        $display("[TB] FAIL mid_restart_write[%0d]: got %h/%h expected %h/%h", i, wrAddr[wb2+i], wrData[wb2+i], BASE + AW'(i), 8'h70 + 8'(i));
      end
    end
  endtask

  task automatic test_start_ignored();
    int wb = wrCount;
    int db = doneCount;
    for (int i = 0; i < NPIX; i++) pushPixel(8'h80 + 8'(i));
    pulseStart();
    repeat (3) tick();
    pulseStart();
    waitDone(db, 100);
    checks++; if (doneCount - db !== 1) begin errors++; $display("[TB] FAIL ign_done_count: got %0d expected 1", doneCount - db); end
    checks++; if (wrCount - wb !== NPIX) begin errors++; $display("[TB] FAIL ign_write_count: got %0d expected %0d", wrCount - wb, NPIX); end
    for (int i = 0; i < NPIX; i++) begin
      checks++;
      if (wrAddr[wb+i] !== BASE + AW'(i) || wrData[wb+i] !== 8'h80 + 8'(i)) begin
        errors++;
        $display("[TB] FAIL ign_write[%0d]: got %h/%h expected %h/%h", i, wrAddr[wb+i], wrData[wb+i], BASE + AW'(i), 8'h80 + 8'(i));
      end
    end
`ifdef FRAME_CHECKSUM_EN
    checks++; if (checksum !== 32'h642) begin errors++; $display("[TB] FAIL ign_checksum: got %h expected 642", checksum); end
`endif
  endtask

  initial begin
    test_reset();
    test_continuous();
    test_back_to_back();
    test_backpressure();
    test_starved();
    test_reset_midframe();
    test_start_ignored();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
